bus_gate_arbiter: RTL and testbench

BUS_GATE_ARBITER -- requirements
Module: bus_gate_arbiter

---
 rtl/bus_gate_arbiter.sv | 141 ++++++++++++++
 tb/tb_bus_gate_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter
//   Grants one of NSRC sources ownership of a shared tristate bus.
//   The grant follows the registered GATE request with one cycle of
//   latency. An optional one-cycle turnaround separates two owners. A
//   multi-bit request is an error: no source is granted, and a sticky
//   flag and a saturating counter record the event.
//
// Parameters
//   WIDTH    bus and per-source data width
//   NSRC     number of sources (bit 0 = GatePC, GateMDR, GateALU, GateMARMUX)
//   TURN_EN  1: idle cycle between different owners, 0: direct handover
//
// Ports
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   GATE       per-source drive request
//   D_IN       source i data at [i*WIDTH +: WIDTH]
//   CLR_ERR    clears CONTENTION / ERR_CNT (a contention in the same cycle wins)
//   BUS        shared bus, Z when no source is granted
//   GNT        registered one-hot grant
//   BUS_VALID  BUS is being driven
//   CONTENTION sticky multi-request flag
//   ERR_CNT    saturating contention-cycle count
//   LAST_VAL   last value driven onto BUS
module bus_gate_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NSRC    = 4,
    parameter bit          TURN_EN = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NSRC-1:0]         GATE,
    input  logic [NSRC*WIDTH-1:0]   D_IN,
    input  logic                    CLR_ERR,
    output logic [WIDTH-1:0]        BUS,
    output logic [NSRC-1:0]         GNT,
    output logic                    BUS_VALID,
    output logic                    CONTENTION,
    output logic [7:0]              ERR_CNT,
    output logic [WIDTH-1:0]        LAST_VAL
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t            state;
    logic [NSRC-1:0]   gate_low;
    logic              gate_multi;
    logic              gate_onehot;
    logic [WIDTH-1:0]  bus_sel;

    // Clearing the lowest set bit leaves something only when two or more
    // bits are set.
    assign gate_low    = GATE & (GATE - NSRC'(1));
    assign gate_multi  = |gate_low;
    assign gate_onehot = (|GATE) & ~gate_multi;

    // GNT is one-hot or zero, so OR-ing the masked slices is a plain mux.
    always_comb begin
        bus_sel = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (GNT[i]) begin
                bus_sel = bus_sel | D_IN[i*WIDTH +: WIDTH];
            end
        end
    end

    assign BUS_VALID = |GNT;
    assign BUS       = BUS_VALID ? bus_sel : 'z;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            GNT        <= '0;
            CONTENTION <= 1'b0;
            ERR_CNT    <= '0;
            LAST_VAL   <= '0;
        end else begin
            if (BUS_VALID) begin
                LAST_VAL <= bus_sel;
            end

            if (gate_multi) begin
                state <= IDLE;
                GNT   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (gate_onehot) begin
                            state <= DRIVE;
                            GNT   <= GATE;
                        end
                    end
                    DRIVE: begin
                        if (!gate_onehot) begin
                            state <= IDLE;
                            GNT   <= '0;
                        end else if (GATE != GNT) begin
                            if (TURN_EN) begin
                                state <= TURN;
                                GNT   <= '0;
                            end else begin
                                GNT   <= GATE;
                            end
                        end
                    end
                    TURN: begin
                        if (gate_onehot) begin
                            state <= DRIVE;
                            GNT   <= GATE;
                        end else begin
                            state <= IDLE;
                            GNT   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        GNT   <= '0;
                    end
                endcase
            end

            // A contention in the same cycle as CLR_ERR restarts the count at 1.
            if (gate_multi) begin
                CONTENTION <= 1'b1;
                if (CLR_ERR) begin
                    ERR_CNT <= 8'd1;
                end else if (ERR_CNT != 8'hFF) begin
                    ERR_CNT <= ERR_CNT + 8'd1;
                end
            end else if (CLR_ERR) begin
                CONTENTION <= 1'b0;
                ERR_CNT    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// tb_bus_gate_arbiter
//   Drives two arbiters (TURN_EN=1 and TURN_EN=0) from the same GATE/D_IN.
//   Expected post-edge values are queued when stimulus is applied and
//   compared after the edge.
module tb_bus_gate_arbiter;

    logic        CLK;
    logic        RST_N;
    logic [3:0]  GATE;
    logic [63:0] D_IN;
    logic        CLR_ERR;

    wire  [15:0] bus1, bus0;
    logic [3:0]  gnt1, gnt0;
    logic        valid1, valid0;
    logic        cont1, cont0;
    logic [7:0]  cnt1, cnt0;
    logic [15:0] last1, last0;

    logic [15:0] d_src [4];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  gnt1;
        logic [3:0]  gnt0;
        logic        cont;
        logic [7:0]  cnt;
        logic [15:0] last;
    } exp_t;

    exp_t sb [$];

    bus_gate_arbiter #(.WIDTH(16), .NSRC(4), .TURN_EN(1'b1)) u_turn (
        .CLK(CLK), .RST_N(RST_N), .GATE(GATE), .D_IN(D_IN), .CLR_ERR(CLR_ERR),
        .BUS(bus1), .GNT(gnt1), .BUS_VALID(valid1), .CONTENTION(cont1),
        .ERR_CNT(cnt1), .LAST_VAL(last1)
    );

    bus_gate_arbiter #(.WIDTH(16), .NSRC(4), .TURN_EN(1'b0)) u_direct (
        .CLK(CLK), .RST_N(RST_N), .GATE(GATE), .D_IN(D_IN), .CLR_ERR(CLR_ERR),
        .BUS(bus0), .GNT(gnt0), .BUS_VALID(valid0), .CONTENTION(cont0),
        .ERR_CNT(cnt0), .LAST_VAL(last0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic load_din();
        D_IN = {d_src[3], d_src[2], d_src[1], d_src[0]};
    endtask

    function automatic logic [15:0] exp_bus(input logic [3:0] g);
        case (g)
            4'b0001: return d_src[0];
            4'b0010: return d_src[1];
            4'b0100: return d_src[2];
            4'b1000: return d_src[3];
            default: return 16'hzzzz;
        endcase
    endfunction

    // One clock: apply GATE/CLR_ERR, queue the expected post-edge state,
    // then compare after the edge.
    task automatic cyc(input logic [3:0] g, input logic clr,
                       input logic [3:0] eg1, input logic [3:0] eg0,
                       input logic ec, input logic [7:0] en, input logic [15:0] el);
        exp_t e;
        GATE    = g;
        CLR_ERR = clr;
        e.gnt1 = eg1;
        e.gnt0 = eg0;
        e.cont = ec;
        e.cnt  = en;
        e.last = el;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check("gnt_turn",   {28'd0, gnt1},   {28'd0, e.gnt1});
        check("gnt_direct", {28'd0, gnt0},   {28'd0, e.gnt0});
        check("valid_turn", {31'd0, valid1}, {31'd0, |e.gnt1});
        check("valid_direct", {31'd0, valid0}, {31'd0, |e.gnt0});
        check("bus_turn",   {16'd0, bus1},   {16'd0, exp_bus(e.gnt1)});
        check("bus_direct", {16'd0, bus0},   {16'd0, exp_bus(e.gnt0)});
        check("contention", {31'd0, cont1},  {31'd0, e.cont});
        check("contention_direct", {31'd0, cont0}, {31'd0, e.cont});
        check("err_cnt",    {24'd0, cnt1},   {24'd0, e.cnt});
        check("err_cnt_direct", {24'd0, cnt0}, {24'd0, e.cnt});
        check("last_val",   {16'd0, last1},  {16'd0, e.last});
        CLR_ERR = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_gnt",   {28'd0, gnt1},   32'd0);
        check("rst_gnt_direct", {28'd0, gnt0}, 32'd0);
        check("rst_bus",   {16'd0, bus1},   {16'd0, 16'hzzzz});
        check("rst_valid", {31'd0, valid1}, 32'd0);
        check("rst_cont",  {31'd0, cont1},  32'd0);
        check("rst_cnt",   {24'd0, cnt1},   32'd0);
        check("rst_last",  {16'd0, last1},  32'd0);
        check("rst_last_direct", {16'd0, last0}, 32'd0);
    endtask

    initial begin
        RST_N   = 1'b0;
        GATE    = 4'b0000;
        CLR_ERR = 1'b0;
        d_src[0] = 16'h1234;
        d_src[1] = 16'h5555;
        d_src[2] = 16'h0C0C;
        d_src[3] = 16'hABCD;
        load_din();

        #12;
        check_reset_state();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Single grant, live D_IN, release.
        cyc(4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'd0, 16'h0000);
        cyc(4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'd0, 16'h1234);
        d_src[0] = 16'h4321;
        load_din();
        #1;
        check("bus_live_din", {16'd0, bus1}, {16'd0, 16'h4321});
        d_src[0] = 16'h1234;
        load_din();
        #1;
        check("bus_live_din_back", {16'd0, bus1}, {16'd0, 16'h1234});
        cyc(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0, 16'h1234);

        // Handover source 0 -> source 2.
        cyc(4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'd0, 16'h1234);
        cyc(4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b0, 8'd0, 16'h1234);
        cyc(4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b0, 8'd0, 16'h1234);
        cyc(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0, 16'h0C0C);

        // Contention for three cycles, then clear.
        cyc(4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'd1, 16'h0C0C);
        cyc(4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'd2, 16'h0C0C);
        cyc(4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'd3, 16'h0C0C);
        cyc(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'd0, 16'h0C0C);

        // Contention arriving while in DRIVE.
        cyc(4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b0, 8'd0, 16'h0C0C);
        cyc(4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'd1, 16'hABCD);
        cyc(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'd0, 16'hABCD);

        // TURN followed by no request returns to IDLE.
        cyc(4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'd0, 16'hABCD);
        cyc(4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b0, 8'd0, 16'h1234);
        cyc(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0, 16'h1234);

        // Saturation, then CLR_ERR colliding with a contention.
        for (int k = 1; k <= 300; k++) begin
            cyc(4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'((k > 255) ? 255 : k), 16'h1234);
        end
        cyc(4'b1100, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'd1, 16'h1234);

        // Reset in the middle of DRIVE, between edges.
        cyc(4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'd1, 16'h1234);
        check("bus_before_reset", {16'd0, bus1}, {16'd0, 16'hABCD});
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_state();
        #1;
        RST_N = 1'b1;

        // First edge after reset evaluates GATE as from IDLE.
        cyc(4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'd0, 16'h0000);
        cyc(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0, 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
